// File: rtl/irq_sequencer.sv
// irq_sequencer: interrupt/exception sequencer for the 5-stage pipeline.
// Edge-detects sources, holds pending/mask, traps on a clean ID slot.
module irq_sequencer #(
    parameter int NUM_SRC  = 4,
    parameter int ID_WIDTH = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic                mask_we,
    input  logic [NUM_SRC-1:0]  mask_wdata,
    input  logic                ack_we,
    input  logic [NUM_SRC-1:0]  ack_wdata,
    input  logic                id_valid,
    input  logic [PC_WIDTH-1:0] id_pc,
    input  logic                stall,
    input  logic                br_flush,
    input  logic                ins_not_in,
    input  logic                eret,
    output logic                IRQ,
    output logic                Kenel,
    output logic                flush,
    output logic [PC_WIDTH-1:0] epc,
    output logic                cause,
    output logic [ID_WIDTH-1:0] src_id,
    output logic [NUM_SRC-1:0]  pending,
    output logic [NUM_SRC-1:0]  mask
);

    typedef enum logic [1:0] {
        USER   = 2'd0,
        REQ    = 2'd1,
        TAKEN  = 2'd2,
        KERNEL = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NUM_SRC-1:0]  r_irq_prev;
    logic [NUM_SRC-1:0]  r_pending;
    logic [NUM_SRC-1:0]  r_mask;
    logic [PC_WIDTH-1:0] r_epc;
    logic                r_cause;
    logic [ID_WIDTH-1:0] r_src_id;
    logic [NUM_SRC-1:0]  w_rise;
    logic [NUM_SRC-1:0]  w_clr;
    logic [NUM_SRC-1:0]  w_active;
    logic                w_armed;
    logic                w_slot;
    logic                w_trap_exc;
    logic                w_trap_irq;
    logic [ID_WIDTH-1:0] w_sel;

    assign w_rise   = irq_src & ~r_irq_prev;
    assign w_clr    = ack_we ? ack_wdata : '0;
    assign w_active = r_pending & r_mask;
    assign w_armed  = |w_active;
    assign w_slot   = id_valid & ~stall & ~br_flush;

    assign pending = r_pending;
    assign mask    = r_mask;
    assign epc     = r_epc;
    assign cause   = r_cause;
    assign src_id  = r_src_id;

    // Lowest-index active source wins.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_sel = i[ID_WIDTH-1:0];
            end
        end
    end

    // Edge history, pending (set beats clear) and mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
        end else begin
            r_irq_prev <= irq_src;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    // Trap record: updated only when a trap is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epc    <= '0;
            r_cause  <= 1'b0;
            r_src_id <= '0;
        end else if (w_trap_exc) begin
            r_epc   <= id_pc;
            r_cause <= 1'b1;
        end else if (w_trap_irq) begin
            r_epc    <= id_pc;
            r_cause  <= 1'b0;
            r_src_id <= w_sel;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= USER;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, controller outputs and trap-accept strobes.
    always_comb begin
        w_next     = r_state;
        IRQ        = 1'b0;
        Kenel      = 1'b0;
        flush      = 1'b0;
        w_trap_exc = 1'b0;
        w_trap_irq = 1'b0;
        unique case (r_state)
            USER: begin
                if (w_slot && ins_not_in) begin
                    w_trap_exc = 1'b1;
                    w_next     = TAKEN;
                end else if (w_armed) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                if (w_slot && ins_not_in) begin
                    w_trap_exc = 1'b1;
                    w_next     = TAKEN;
                end else if (!w_armed) begin
                    w_next = USER;
                end else if (w_slot) begin
                    IRQ        = 1'b1;
                    w_trap_irq = 1'b1;
                    w_next     = TAKEN;
                end
            end
            TAKEN: begin
                flush  = 1'b1;
                Kenel  = 1'b1;
                w_next = KERNEL;
            end
            KERNEL: begin
                Kenel = 1'b1;
                if (eret && w_slot) begin
                    w_next = USER;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: scoreboard bench for irq_sequencer.
// Expected trap records are queued at stimulus time and popped on flush.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_src;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        ack_we;
    logic [3:0]  ack_wdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        stall;
    logic        br_flush;
    logic        ins_not_in;
    logic        eret;
    logic        IRQ;
    logic        Kenel;
    logic        flush;
    logic [31:0] epc;
    logic        cause;
    logic [1:0]  src_id;
    logic [3:0]  pending;
    logic [3:0]  mask;

    typedef struct {
        logic [31:0] epc;
        logic        cause;
        logic [1:0]  src;
    } trap_t;

    trap_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    irq_sequencer #(
        .NUM_SRC  (4),
        .ID_WIDTH (2),
        .PC_WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack_we     (ack_we),
        .ack_wdata  (ack_wdata),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .stall      (stall),
        .br_flush   (br_flush),
        .ins_not_in (ins_not_in),
        .eret       (eret),
        .IRQ        (IRQ),
        .Kenel      (Kenel),
        .flush      (flush),
        .epc        (epc),
        .cause      (cause),
        .src_id     (src_id),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic c,
                        input logic [1:0] s);
        trap_t t;
        t.epc   = pc;
        t.cause = c;
        t.src   = s;
        q.push_back(t);
    endtask

    // Optionally ack, then return from kernel with eret on a clean slot.
    task automatic leave_kernel(input logic [3:0] ackv);
        ack_we    = 1'b1;
        ack_wdata = ackv;
        id_valid  = 1'b0;
        tick();
        ack_we   = 1'b0;
        eret     = 1'b1;
        id_valid = 1'b1;
        tick();
        eret     = 1'b0;
        id_valid = 1'b0;
        chk("eret_kenel", {31'd0, Kenel}, 32'd0);
    endtask

    // Scoreboard: every flush must match the oldest queued trap.
    always @(negedge clk) begin
        if (!reset && flush) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_flush", 32'd1, 32'd0);
            end else begin
                trap_t e;
                e = q.pop_front();
                chk("sb_epc", epc, e.epc);
                chk("sb_cause", {31'd0, cause}, {31'd0, e.cause});
                chk("sb_src", {30'd0, src_id}, {30'd0, e.src});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        irq_src    = 4'b0010;
        mask_we    = 1'b0;
        mask_wdata = '0;
        ack_we     = 1'b0;
        ack_wdata  = '0;
        id_valid   = 1'b0;
        id_pc      = '0;
        stall      = 1'b0;
        br_flush   = 1'b0;
        ins_not_in = 1'b0;
        eret       = 1'b0;
        #1;
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_kenel", {31'd0, Kenel}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rel_pending", {28'd0, pending}, 32'd0);
        // First edge after release sees the held level as a rise.
        tick();
        chk("rel_rise", {28'd0, pending}, 32'h2);
        ack_we     = 1'b1;
        ack_wdata  = 4'b0010;
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        ack_we  = 1'b0;
        mask_we = 1'b0;
        chk("t1_mask", {28'd0, mask}, 32'hF);
        chk("t1_ackd", {28'd0, pending}, 32'd0);
        irq_src = 4'b0110;
        tick();
        chk("t1_pending", {28'd0, pending}, 32'h4);
        id_valid = 1'b1;
        id_pc    = 32'h40;
        push(32'h40, 1'b0, 2'd2);
        tick();
        chk("t1_irq", {31'd0, IRQ}, 32'd1);
        tick();
        chk("t1_flush", {31'd0, flush}, 32'd1);
        chk("t1_kenel", {31'd0, Kenel}, 32'd1);
        chk("t1_irq_taken", {31'd0, IRQ}, 32'd0);
        id_valid = 1'b0;
        tick();
        chk("t1_flush_1cyc", {31'd0, flush}, 32'd0);
        irq_src = 4'b0000;
        leave_kernel(4'b0100);

        // Interrupt held off by stalls and a branch flush.
        irq_src  = 4'b1000;
        id_valid = 1'b1;
        stall    = 1'b1;
        id_pc    = 32'h70;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_irq", {31'd0, IRQ}, 32'd0);
            tick();
        end
        stall    = 1'b0;
        br_flush = 1'b1;
        #1;
        chk("t2_br_irq", {31'd0, IRQ}, 32'd0);
        tick();
        br_flush = 1'b0;
        id_pc    = 32'h80;
        push(32'h80, 1'b0, 2'd3);
        #1;
        chk("t2_irq", {31'd0, IRQ}, 32'd1);
        tick();
        chk("t2_flush", {31'd0, flush}, 32'd1);
        id_valid = 1'b0;
        tick();
        irq_src = 4'b0000;
        leave_kernel(4'b1000);

        // Illegal instruction preempts a requested interrupt.
        irq_src = 4'b0010;
        tick();
        tick();
        id_valid   = 1'b1;
        ins_not_in = 1'b1;
        id_pc      = 32'h100;
        #1;
        chk("t3_irq", {31'd0, IRQ}, 32'd0);
        push(32'h100, 1'b1, 2'd3);
        tick();
        chk("t3_pending", {28'd0, pending}, 32'h2);
        ins_not_in = 1'b0;
        id_valid   = 1'b0;
        tick();
        irq_src = 4'b0000;
        leave_kernel(4'b0000);
        id_valid = 1'b1;
        id_pc    = 32'h200;
        push(32'h200, 1'b0, 2'd1);
        tick();
        chk("t3_irq_after", {31'd0, IRQ}, 32'd1);
        tick();
        chk("t3_flush", {31'd0, flush}, 32'd1);
        id_valid = 1'b0;
        tick();
        leave_kernel(4'b0010);

        // Set beats clear; priority picks lowest index.
        mask_we    = 1'b1;
        mask_wdata = 4'b0000;
        tick();
        mask_we   = 1'b0;
        irq_src   = 4'b0001;
        ack_we    = 1'b1;
        ack_wdata = 4'b0001;
        tick();
        chk("t4_set_wins", {28'd0, pending}, 32'h1);
        irq_src = 4'b1011;
        tick();
        chk("t4_pending", {28'd0, pending}, 32'hA);
        ack_we     = 1'b0;
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we  = 1'b0;
        id_valid = 1'b1;
        id_pc    = 32'h300;
        push(32'h300, 1'b0, 2'd1);
        tick();
        chk("t4_irq", {31'd0, IRQ}, 32'd1);
        tick();
        chk("t4_flush", {31'd0, flush}, 32'd1);
        id_valid = 1'b0;
        tick();

        // eret ignored under stall; re-request while still armed.
        eret     = 1'b1;
        stall    = 1'b1;
        id_valid = 1'b1;
        tick();
        chk("t5_stall_kenel", {31'd0, Kenel}, 32'd1);
        stall = 1'b0;
        tick();
        chk("t5_exit_kenel", {31'd0, Kenel}, 32'd0);
        eret     = 1'b0;
        id_valid = 1'b0;
        #1;
        chk("t5_user_irq", {31'd0, IRQ}, 32'd0);
        tick();
        chk("t5_req_noslot", {31'd0, IRQ}, 32'd0);
        id_valid = 1'b1;
        id_pc    = 32'h400;
        #1;
        chk("t5_req_irq", {31'd0, IRQ}, 32'd1);
        tick();
        chk("t6_flush", {31'd0, flush}, 32'd1);
        chk("t6_epc", epc, 32'h400);
        chk("t6_src", {30'd0, src_id}, 32'd1);

        // Asynchronous reset in the middle of TAKEN.
        irq_src = 4'b0000;
        reset   = 1'b1;
        #1;
        chk("t6_rst_flush", {31'd0, flush}, 32'd0);
        chk("t6_rst_kenel", {31'd0, Kenel}, 32'd0);
        chk("t6_rst_irq", {31'd0, IRQ}, 32'd0);
        tick();
        tick();
        reset    = 1'b0;
        id_valid = 1'b0;
        tick();
        chk("t6_pending", {28'd0, pending}, 32'd0);
        chk("t6_mask", {28'd0, mask}, 32'd0);
        chk("t6_kenel", {31'd0, Kenel}, 32'd0);
        id_valid = 1'b1;
        #1;
        chk("t6_user_irq", {31'd0, IRQ}, 32'd0);
        tick();
        chk("t6_no_flush", {31'd0, flush}, 32'd0);
        chk("sb_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
